// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single-ported data memory.
// Optional build macro: DMEM_ARB_MISALIGN_CHECK_EN adds misaligned H/HU/W access errors.
module dmem_arbiter #(
    parameter int unsigned Numbit    = 32,
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [Numbit-1:0] cpu_addr,
    input  logic [Numbit-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    output logic [Numbit-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [2:0]        dma_funct3,
    input  logic [Numbit-1:0] dma_addr,
    input  logic [Numbit-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic              dma_err,
    output logic [Numbit-1:0] dma_rdata,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic [2:0]        mem_funct3,
    output logic [Numbit-1:0] mem_Address,
    output logic [Numbit-1:0] mem_Write_data,
    input  logic [Numbit-1:0] mem_Read_data
);

    localparam int unsigned AW = Numbit + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              last_dma;
    logic              sel_dma;
    logic              we_q;
    logic              err_q;
    logic              rst_d;
    logic [2:0]        f3_q;
    logic [Numbit-1:0] addr_q;
    logic [Numbit-1:0] wdata_q;
    logic [Numbit-1:0] rdata_q;

    logic              grant_ok;
    logic              any_req;
    logic              pick_dma;
    logic              acc;
    logic              resp;
    logic              req_we;
    logic [2:0]        req_f3;
    logic [Numbit-1:0] req_addr;
    logic [Numbit-1:0] req_wdata;

    // Access error: bounds overrun computed one bit wider so high addresses cannot wrap.
    function automatic logic req_err(input logic [2:0] f3, input logic [Numbit-1:0] a);
        logic [AW-1:0] size;
        logic [AW-1:0] end_addr;
        logic          bad;
        case (f3[1:0])
            2'd0:    size = AW'(1);
            2'd1:    size = AW'(2);
            default: size = AW'(4);
        endcase
        end_addr = AW'(a) + size;
        bad      = end_addr > AW'(MEM_BYTES);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) begin
            bad = 1'b1;
        end
        if (f3 == 3'd2 && a[1:0] != 2'b00) begin
            bad = 1'b1;
        end
`endif
        return bad;
    endfunction

    // Arbitration: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        any_req   = cpu_req | dma_req;
        pick_dma  = dma_req && (!cpu_req || !last_dma);
        grant_ok  = (state != ACCESS) && !reset && !rst_d;
        req_we    = pick_dma ? dma_we     : cpu_we;
        req_f3    = pick_dma ? dma_funct3 : cpu_funct3;
        req_addr  = pick_dma ? dma_addr   : cpu_addr;
        req_wdata = pick_dma ? dma_wdata  : cpu_wdata;
    end

    always_ff @(posedge clk) begin
        rst_d <= reset;
        if (reset) begin
            state    <= IDLE;
            last_dma <= 1'b1;
            sel_dma  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (grant_ok && any_req) begin
                        state    <= ACCESS;
                        last_dma <= pick_dma;
                        sel_dma  <= pick_dma;
                        we_q     <= req_we;
                        f3_q     <= req_f3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= req_err(req_f3, req_addr);
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state   <= RESP;
                    rdata_q <= (!we_q && !err_q) ? mem_Read_data : '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an aborted access never reaches memory or the requester.
    always_comb begin
        acc            = (state == ACCESS) && !reset;
        resp           = (state == RESP) && !reset;
        cpu_gnt        = grant_ok && any_req && !pick_dma;
        dma_gnt        = grant_ok && any_req && pick_dma;
        mem_MemWrite   = acc && we_q && !err_q;
        mem_MemRead    = acc && !we_q && !err_q;
        mem_funct3     = acc ? f3_q : 3'd0;
        mem_Address    = acc ? addr_q : '0;
        mem_Write_data = (acc && we_q) ? wdata_q : '0;
        cpu_rvalid     = resp && !sel_dma;
        cpu_err        = resp && !sel_dma && err_q;
        cpu_rdata      = (resp && !sel_dma) ? rdata_q : '0;
        dma_rvalid     = resp && sel_dma;
        dma_err        = resp && sel_dma && err_q;
        dma_rdata      = (resp && sel_dma) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: byte-array memory device plus a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned NB = 32;
    localparam int unsigned MB = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
    logic [2:0]    cpu_funct3;
    logic [NB-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid, dma_err;
    logic [2:0]    dma_funct3;
    logic [NB-1:0] dma_addr, dma_wdata, dma_rdata;
    logic          mem_MemWrite, mem_MemRead;
    logic [2:0]    mem_funct3;
    logic [NB-1:0] mem_Address, mem_Write_data, mem_Read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.Numbit(NB), .MEM_BYTES(MB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
        .dma_rdata(dma_rdata),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_funct3(mem_funct3),
        .mem_Address(mem_Address), .mem_Write_data(mem_Write_data), .mem_Read_data(mem_Read_data)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        dma;
        logic [31:0] rdata;
    } txn_t;

    logic [7:0] dev_mem [MB];
    logic [7:0] ref_mem [MB];

    function automatic int unsigned size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [7:0] b0, b1, b2, b3);
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd4:    return {24'd0, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd5:    return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Memory device: combinational read with RV32 extension, byte-lane writes on the clock.
    always_comb begin
        mem_Read_data = load_val(mem_funct3,
                                 dev_mem[11'(mem_Address)], dev_mem[11'(mem_Address + 32'd1)],
                                 dev_mem[11'(mem_Address + 32'd2)], dev_mem[11'(mem_Address + 32'd3)]);
    end

    always @(posedge clk) begin
        if (mem_MemWrite) begin
            for (int i = 0; i < int'(size_of(mem_funct3)); i++) begin
                dev_mem[11'(mem_Address + 32'(i))] <= mem_Write_data[8*i +: 8];
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      next_grant = 0;
    longint      mem_cyc = -1;
    longint      resp_cyc = -1;
    logic        last_dma = 1'b1;
    logic        g_cpu, g_dma;
    logic        gaps = 1'b0;
    txn_t        cur;
    txn_t        cpu_q[$];
    txn_t        dma_q[$];
    int          grant_log[$];
    logic [31:0] cpu_rd_log[$];
    logic        last_cpu_err, last_dma_err;
    logic [31:0] last_dma_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Spec error rule in plain 64-bit arithmetic.
    function automatic logic model_err(input logic [2:0] f3, input logic [31:0] a);
        logic [63:0] e;
        logic        bad;
        e   = {32'd0, a} + 64'(size_of(f3));
        bad = e > 64'(MB);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) bad = 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    // Transaction-level expectation for the current cycle: grant at N, access at N+1, response at N+2.
    task automatic model_cycle();
        logic        ew, er, pick;
        logic [2:0]  ef3;
        logic [31:0] ea, ewd, erd;
        g_cpu = 1'b0;
        g_dma = 1'b0;
        if (cpu_gnt) grant_log.push_back(0);
        if (dma_gnt) grant_log.push_back(1);
        if (cpu_rvalid) begin
            cpu_rd_log.push_back(cpu_rdata);
            last_cpu_err = cpu_err;
        end
        if (dma_rvalid) begin
            last_dma_rd  = dma_rdata;
            last_dma_err = dma_err;
        end
        if (reset) begin
            check_eq("rst_gnt", {62'd0, cpu_gnt, dma_gnt}, 64'd0);
            check_eq("rst_resp", {60'd0, cpu_rvalid, cpu_err, dma_rvalid, dma_err}, 64'd0);
            check_eq("rst_rdata", {cpu_rdata, dma_rdata}, 64'd0);
            check_eq("rst_mem", {27'd0, mem_MemWrite, mem_MemRead, mem_funct3, mem_Address}, 64'd0);
            check_eq("rst_wdata", 64'(mem_Write_data), 64'd0);
            mem_cyc    = -1;
            resp_cyc   = -1;
            next_grant = cyc + 2;
            last_dma   = 1'b1;
            return;
        end
        ew = 1'b0; er = 1'b0; ef3 = 3'd0; ea = 32'd0; ewd = 32'd0;
        if (cyc == mem_cyc) begin
            ew  = cur.we && !cur.err;
            er  = !cur.we && !cur.err;
            ef3 = cur.f3;
            ea  = cur.addr;
            ewd = cur.we ? cur.wdata : 32'd0;
            if (!cur.err && cur.we) begin
                for (int i = 0; i < int'(size_of(cur.f3)); i++)
                    ref_mem[11'(cur.addr + 32'(i))] = cur.wdata[8*i +: 8];
            end else if (!cur.err) begin
                cur.rdata = load_val(cur.f3, ref_mem[11'(cur.addr)], ref_mem[11'(cur.addr + 32'd1)],
                                     ref_mem[11'(cur.addr + 32'd2)], ref_mem[11'(cur.addr + 32'd3)]);
            end
        end
        check_eq("mem_en", {62'd0, mem_MemWrite, mem_MemRead}, {62'd0, ew, er});
        check_eq("mem_f3_addr", {29'd0, mem_funct3, mem_Address}, {29'd0, ef3, ea});
        check_eq("mem_wdata", 64'(mem_Write_data), 64'(ewd));
        if (cyc == resp_cyc) begin
            erd = (cur.err || cur.we) ? 32'd0 : cur.rdata;
            check_eq("rvalid", {62'd0, cpu_rvalid, dma_rvalid}, {62'd0, !cur.dma, cur.dma});
            check_eq("err", {62'd0, cpu_err, dma_err}, {62'd0, cur.err && !cur.dma, cur.err && cur.dma});
            check_eq("rdata", {cpu_rdata, dma_rdata}, {cur.dma ? 32'd0 : erd, cur.dma ? erd : 32'd0});
        end else begin
            check_eq("idle_resp", {28'd0, cpu_rvalid, cpu_err, dma_rvalid, dma_err, 32'd0}, 64'd0);
            check_eq("idle_rdata", {cpu_rdata, dma_rdata}, 64'd0);
        end
        if (cyc >= next_grant && (cpu_req || dma_req)) begin
            pick = (cpu_req && dma_req) ? !last_dma : dma_req;
            g_cpu = !pick;
            g_dma = pick;
            cur.dma   = pick;
            cur.we    = pick ? dma_we : cpu_we;
            cur.f3    = pick ? dma_funct3 : cpu_funct3;
            cur.addr  = pick ? dma_addr : cpu_addr;
            cur.wdata = pick ? dma_wdata : cpu_wdata;
            cur.err   = model_err(cur.f3, cur.addr);
            cur.rdata = 32'd0;
            mem_cyc    = cyc + 1;
            resp_cyc   = cyc + 2;
            next_grant = cyc + 2;
            last_dma   = pick;
        end
        check_eq("gnt", {62'd0, cpu_gnt, dma_gnt}, {62'd0, g_cpu, g_dma});
    endtask

    task automatic step();
        txn_t t;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (g_cpu) cpu_req = 1'b0;
        if (g_dma) dma_req = 1'b0;
        if (!cpu_req) begin
            cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom); cpu_funct3 = 3'($urandom);
            if (cpu_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                t = cpu_q.pop_front();
                cpu_req = 1'b1; cpu_we = t.we; cpu_funct3 = t.f3; cpu_addr = t.addr; cpu_wdata = t.wdata;
            end
        end
        if (!dma_req) begin
            dma_addr = $urandom; dma_wdata = $urandom; dma_we = 1'($urandom); dma_funct3 = 3'($urandom);
            if (dma_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                t = dma_q.pop_front();
                dma_req = 1'b1; dma_we = t.we; dma_funct3 = t.f3; dma_addr = t.addr; dma_wdata = t.wdata;
            end
        end
    endtask

    task automatic push(input logic dma, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.we = we; t.f3 = f3; t.addr = a; t.wdata = wd; t.err = 1'b0; t.dma = dma; t.rdata = 32'd0;
        if (dma) dma_q.push_back(t);
        else     cpu_q.push_back(t);
    endtask

    task automatic run_idle(input int max, input logic rand_rst);
        int n = 0;
        while ((cpu_q.size() > 0 || dma_q.size() > 0 || cpu_req || dma_req || cyc <= resp_cyc) && n < max) begin
            if (rand_rst && $urandom_range(199) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
            n++;
        end
        check_eq("run_timeout", 64'(n >= max), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic txn_t rnd_txn(input logic dma);
        txn_t t;
        int   k;
        logic [2:0] f3s [5];
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;
        t.we    = 1'($urandom);
        t.f3    = ($urandom_range(15) == 0) ? 3'(6 + $urandom_range(1)) : f3s[$urandom_range(4)];
        k       = $urandom_range(99);
        if (k < 60)      t.addr = $urandom_range(MB - 1);
        else if (k < 85) t.addr = MB - 8 + $urandom_range(7);
        else if (k < 95) t.addr = 4 * $urandom_range(MB / 4 - 1);
        else             t.addr = 32'hFFFF_FFF0 + $urandom_range(15);
        t.wdata = $urandom;
        t.err = 1'b0; t.dma = dma; t.rdata = 32'd0;
        return t;
    endfunction

    initial begin
        logic        exp_mis;
        int          n;
        cpu_req = 0; cpu_we = 0; cpu_funct3 = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_funct3 = 0; dma_addr = 0; dma_wdata = 0;
        last_cpu_err = 1'b0; last_dma_err = 1'b0; last_dma_rd = 32'd0;
        for (int i = 0; i < int'(MB); i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Store word then load it back.
        push(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        push(0, 0, 3'd2, 32'h10, 32'h0);
        run_idle(50, 0);
        check_eq("sw_lw_data", 64'(cpu_rd_log[$]), 64'hDEAD_BEEF);
        check_eq("sw_lw_err", 64'(last_cpu_err), 64'd0);

        // Both requesters held from reset alternate CPU first.
        for (int i = 0; i < 2; i++) begin
            push(0, 0, 3'd2, 32'h100 + 32'(4 * i), 0);
            push(1, 0, 3'd2, 32'h200 + 32'(4 * i), 0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        grant_log.delete();
        run_idle(50, 0);
        check_eq("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4)
            check_eq("rr_order", {60'd0, 1'(grant_log[0]), 1'(grant_log[1]), 1'(grant_log[2]), 1'(grant_log[3])},
                     64'b0101);

        // Out-of-bounds DMA word load.
        push(1, 0, 3'd2, 32'h7FE, 0);
        run_idle(50, 0);
        check_eq("oob_err", 64'(last_dma_err), 64'd1);
        check_eq("oob_rdata", 64'(last_dma_rd), 64'd0);

        // Misaligned halfword load.
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        push(0, 0, 3'd1, 32'h21, 0);
        run_idle(50, 0);
        check_eq("mis_h_err", 64'(last_cpu_err), 64'(exp_mis));

        // Byte store, then signed and unsigned byte loads.
        push(0, 1, 3'd0, 32'h30, 32'h0000_0080);
        push(0, 0, 3'd0, 32'h30, 0);
        push(0, 0, 3'd4, 32'h30, 0);
        run_idle(50, 0);
        check_eq("lb_data", 64'(cpu_rd_log[$-1]), 64'hFFFF_FF80);
        check_eq("lbu_data", 64'(cpu_rd_log[$]), 64'h0000_0080);
        check_eq("lbu_err", 64'(last_cpu_err), 64'd0);

        // Reset during the access cycle of a store drops it.
        push(0, 1, 3'd2, 32'h40, 32'h1234_5678);
        n = 0;
        do begin
            step();
            n++;
        end while (!g_cpu && n < 20);
        check_eq("abort_gnt_timeout", 64'(n >= 20), 64'd0);
        do_reset();
        grant_log.delete();
        push(1, 0, 3'd2, 32'h44, 0);
        push(0, 0, 3'd2, 32'h40, 0);
        run_idle(50, 0);
        check_eq("abort_first_cpu", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFF, 64'd0);

        // Random traffic with gaps and occasional reset.
        gaps = 1'b1;
        for (int i = 0; i < 150; i++) begin
            cpu_q.push_back(rnd_txn(0));
            dma_q.push_back(rnd_txn(1));
        end
        run_idle(5000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
